// File: rtl/util_mux_arb_pkg.sv
// Shared types and limits for the utility multiplexer/arbiter family.
package util_pkg;

  typedef enum logic [1:0] {
    MUX_SEL  = 2'd0,
    MUX_PRIO = 2'd1,
    MUX_RR   = 2'd2
  } mux_mode_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  localparam int UTIL_MUX_MAX_N = 16;

endpackage

// File: rtl/util_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping to the lowest requester below ptr.
module util_rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Descending scans let the lowest matching index win; the second pass
  // overrides the wrap-around pick whenever a requester sits at or above ptr.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c]) begin
        gnt_idx = SELW'(c);
        gnt_any = 1'b1;
      end
    end
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c] && (SELW'(c) >= ptr)) begin
        gnt_idx = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/util_mux_arb.sv
// N-channel valid/ready multiplexer with select, fixed-priority or round-robin
// grant, burst locking until the last beat, and one registered output stage.
module util_mux_arb
  import util_pkg::*;
#(
  parameter  int        W    = 8,
  parameter  int        N    = 4,
  parameter  mux_mode_t MODE = MUX_SEL,
  localparam int        SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  lock_state_t     state_q;
  logic [SELW-1:0] lock_chan_q;
  logic [SELW-1:0] rr_ptr_q;
  logic [SELW-1:0] rr_ptr_d;
  logic [W-1:0]    out_data_q;
  logic            out_last_q;
  logic [SELW-1:0] out_chan_q;
  logic            out_valid_q;

  logic [SELW-1:0] arb_ptr_s;
  logic [SELW-1:0] arb_idx_s;
  logic            arb_any_s;
  logic [SELW-1:0] grant_s;
  logic            grant_any_s;
  logic            slot_free_s;
  logic            xfer_s;
  logic [W-1:0]    gnt_data_s;
  logic            gnt_last_s;
  logic            gnt_valid_s;
  logic [N-1:0]    in_ready_s;

  // Fixed priority is round-robin with the pointer pinned at channel 0.
  assign arb_ptr_s = (MODE == MUX_RR) ? rr_ptr_q : '0;

  util_rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (arb_ptr_s),
    .gnt_idx (arb_idx_s),
    .gnt_any (arb_any_s)
  );

  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_s     = lock_chan_q;
      grant_any_s = 1'b1;
    end else if (MODE == MUX_SEL) begin
      grant_s     = sel;
      grant_any_s = (32'(sel) < 32'(N));
    end else begin
      grant_s     = arb_idx_s;
      grant_any_s = arb_any_s;
    end
  end

  assign slot_free_s = !out_valid_q || out_ready;

  always_comb begin
    gnt_data_s  = '0;
    gnt_last_s  = 1'b0;
    gnt_valid_s = 1'b0;
    in_ready_s  = '0;
    for (int c = 0; c < N; c++) begin
      if (grant_s == SELW'(c)) begin
        gnt_data_s    = in_data[c*W +: W];
        gnt_last_s    = in_last[c];
        gnt_valid_s   = in_valid[c];
        in_ready_s[c] = slot_free_s && grant_any_s && !rst;
      end
    end
  end

  assign xfer_s   = grant_any_s && slot_free_s && gnt_valid_s;
  assign rr_ptr_d = (grant_s == SELW'(N - 1)) ? '0 : grant_s + 1'b1;

  // Output stage, burst lock FSM and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer_s) begin
      out_data_q  <= gnt_data_s;
      out_last_q  <= gnt_last_s;
      out_chan_q  <= grant_s;
      out_valid_q <= 1'b1;
      if (gnt_last_s) begin
        state_q <= ST_UNLOCKED;
        if (MODE == MUX_RR) begin
          rr_ptr_q <= rr_ptr_d;
        end
      end else begin
        state_q     <= ST_LOCKED;
        lock_chan_q <= grant_s;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/util_mux_arb.md
Name: util_mux_arb

Overview:
- Parametrised N-channel, W-bit multiplexer with one registered output stage and a valid/ready handshake on every input and on the output.
- Used wherever several producers share one sink: bus masters onto the internal data bus, DMA versus CPU access, and similar.
- Three selection modes: explicit select, fixed priority, round-robin. Bursts are locked to one channel until the beat marked last.

Parameters:
- W, 8: data width in bits.
- N, 4: number of input channels, 2..16.
- MODE, MUX_SEL: selection mode, one of MUX_SEL, MUX_PRIO, MUX_RR.
- SELW, $clog2(N): select/channel-index width. Derived; never overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sel  in  SELW  channel select. Used only in MUX_SEL.
- in_data  in  N*W  flattened inputs; channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-burst marker.
- in_ready  out  N  per-channel ready. One-hot or zero.
- out_data  out  W  registered output data.
- out_last  out  1  registered last.
- out_chan  out  SELW  channel index of the current output beat.
- out_valid  out  1  output valid.
- out_ready  in  1  sink ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_chan=0, RR pointer=0, lock cleared (state UNLOCKED). in_ready is forced to 0 while rst is high.
- Output stage: accepts a beat when it is empty (!out_valid) or draining (out_ready). Accept condition: slot_free = !out_valid | out_ready.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1. Full throughput is one beat per cycle.
- out_data, out_last and out_chan hold stable while out_valid && !out_ready.
- Grant g is computed combinationally each cycle:
  - UNLOCKED, MUX_SEL: g = sel. If sel >= N, there is no grant.
  - UNLOCKED, MUX_PRIO: lowest-index valid channel.
  - UNLOCKED, MUX_RR: first valid channel at or after the RR pointer, with wrap-around modulo N.
  - LOCKED (any mode): g = the locked channel. sel and other valids are ignored.
- Ready: in_ready[g] = slot_free & grant_exists. All other bits of in_ready are 0.
- Transfer: in_valid[g] & in_ready[g]. On a transfer: out_data <= in_data[g], out_last <= in_last[g], out_chan <= g, out_valid <= 1.
- Otherwise, if out_ready is high, out_valid <= 0.
- State machine:
  - UNLOCKED -> LOCKED(g) on a transfer with in_last[g]=0.
  - LOCKED -> UNLOCKED on a transfer with in_last[g]=1.
  - A transfer with last=1 while UNLOCKED stays UNLOCKED (single-beat burst).
- RR pointer: on a transfer with last=1 in MUX_RR, the pointer becomes (g+1) mod N. The pointer is unchanged by mid-burst beats. For non-power-of-two N, wrap to 0 after N-1.
- Boundary conditions:
  - No valid channel: no transfer; output drains normally.
  - Locked channel drops valid mid-burst: the lock is held and other channels wait (no preemption).
  - Simultaneous drain and accept in one cycle: out_valid stays 1 and the new beat replaces the old one.
  - sel changes mid-burst: ignored until unlock.
  - Reset mid-burst: the lock and any beat held in the output register are discarded.

Decomposition:
- Package util_pkg:
  - typedef enum mux_mode_t {MUX_SEL, MUX_PRIO, MUX_RR}.
  - Localparam limits UTIL_MUX_MAX_N = 16.
- Sub-module util_rr_arbiter (N; in: req[N], ptr[SELW]; out: gnt_idx, gnt_any) is combinational.
- The RR pointer register, lock FSM and output stage live in util_mux_arb.
- MUX_PRIO reuses util_rr_arbiter with ptr tied to 0.

Test Plan:
- Reset during traffic: assert rst for 1 cycle mid-burst -> out_valid=0, in_ready=0 while rst=1, and the next burst is granted fresh.
- MUX_SEL, N=4, W=8, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, last=1, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
- MUX_SEL backpressure: out_ready=0 for 3 cycles after a beat 8'h3C -> out_data holds 8'h3C and in_ready=0. Release -> the next beat follows the cycle after, with no gap and no loss.
- MUX_PRIO: channels 1 and 3 valid, single-beat -> channel 1 drains first; channel 3 wins only once channel 1 is idle.
- MUX_RR: all 4 channels continuously valid with single-beat last=1 -> out_chan sequence 0,1,2,3,0; the pointer wraps.
- Burst lock, MUX_RR: channel 0 sends 3 beats (last on the third) while channel 1 is valid -> out_chan=0,0,0 then 1. Dropping channel 0 valid for 2 cycles mid-burst produces no channel-1 beats during the gap.
